// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: micro-op, physical register and FU bus payloads.
package alu_issue_queue_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PRN_W    = 6;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned IQ_DEPTH = 8;

  typedef logic [PRN_W-1:0] prn_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    prn_t            prd;
    logic [XLEN-1:0] rs1val;
    logic [XLEN-1:0] rs2val;
  } fu_input_t;

  typedef struct packed {
    prn_t            prd;
    logic [XLEN-1:0] rdval;
  } fu_output_t;

  typedef struct packed {
    fu_input_t payload;
    prn_t      prs1;
    prn_t      prs2;
    logic      rs1_rdy;
    logic      rs2_rdy;
  } iq_uop_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned iq_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned IQ_CNT_W = iq_cnt_w(IQ_DEPTH);

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, writeback-broadcast and issue signals of the ALU issue queue.
interface alu_issue_queue_if import alu_issue_queue_pkg::*; #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WB_PORTS = 2
) ();

  localparam int unsigned CNT_W = iq_cnt_w(DEPTH);

  logic                          flush_i;
  logic                          disp_valid_i;
  logic                          disp_ready_o;
  iq_uop_t                       disp_uop_i;
  logic       [WB_PORTS-1:0]     wb_valid_i;
  fu_output_t [WB_PORTS-1:0]     wb_i;
  logic                          iss_valid_o;
  logic                          iss_ready_i;
  fu_input_t                     fuinput_o;
  logic       [CNT_W-1:0]        count_o;

  modport master (
    output flush_i, disp_valid_i, disp_uop_i, wb_valid_i, wb_i, iss_ready_i,
    input  disp_ready_o, iss_valid_o, fuinput_o, count_o
  );

  modport slave (
    input  flush_i, disp_valid_i, disp_uop_i, wb_valid_i, wb_i, iss_ready_i,
    output disp_ready_o, iss_valid_o, fuinput_o, count_o
  );

endinterface

// File: rtl/iq_oldest_ready_pick.sv
// Lowest-index priority picker: one-hot grant of the oldest requesting entry.
module iq_oldest_ready_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         found_o
);

  always_comb begin
    logic hit;
    hit     = 1'b0;
    grant_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req_i[i] && !hit) begin
        grant_o[i] = 1'b1;
        hit        = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Data-capture collapsing issue queue feeding the ALU; entry 0 is always the oldest.
// Optional IQ_WAKEUP_BYPASS_EN lets select see this cycle's writeback matches.
module alu_issue_queue import alu_issue_queue_pkg::*; #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WB_PORTS = 2
) (
  input logic              clk,
  input logic              rst,
  alu_issue_queue_if.slave io
);

  localparam int unsigned CNT_W = iq_cnt_w(DEPTH);

  logic    [DEPTH-1:0] valid_q, valid_d;
  iq_uop_t             entry_q [DEPTH];
  iq_uop_t             entry_d [DEPTH];
  logic    [CNT_W-1:0] count_q, count_d;

  iq_uop_t             woke [DEPTH+1];
  logic    [DEPTH:0]   valid_ext;
  iq_uop_t             disp_woke;
  logic    [DEPTH-1:0] rdy_vec;
  logic    [DEPTH-1:0] grant;
  logic                found;
  logic                disp_ready;
  logic                disp_fire;
  logic                iss_fire;
  logic    [CNT_W-1:0] disp_slot;
  fu_input_t           sel_payload;

  // Capture any broadcast matching a not-yet-ready operand; lowest port index wins.
  function automatic iq_uop_t wake(input iq_uop_t u,
                                   input logic [WB_PORTS-1:0] v,
                                   input fu_output_t [WB_PORTS-1:0] wb);
    iq_uop_t r;
    r = u;
    for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
      if (v[p] && !u.rs1_rdy && (wb[p].prd == u.prs1)) begin
        r.rs1_rdy        = 1'b1;
        r.payload.rs1val = wb[p].rdval;
      end
      if (v[p] && !u.rs2_rdy && (wb[p].prd == u.prs2)) begin
        r.rs2_rdy        = 1'b1;
        r.payload.rs2val = wb[p].rdval;
      end
    end
    return r;
  endfunction

  // Wakeup view of every entry; the extra top slot is an empty filler for compaction.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woke[i] = wake(entry_q[i], io.wb_valid_i, io.wb_i);
    end
    woke[DEPTH] = '0;
    valid_ext   = {1'b0, valid_q};
    disp_woke   = wake(io.disp_uop_i, io.wb_valid_i, io.wb_i);
  end

  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef IQ_WAKEUP_BYPASS_EN
      rdy_vec[i] = valid_q[i] & woke[i].rs1_rdy & woke[i].rs2_rdy;
`else
      rdy_vec[i] = valid_q[i] & entry_q[i].rs1_rdy & entry_q[i].rs2_rdy;
`endif
    end
  end

  iq_oldest_ready_pick #(.N(DEPTH)) u_pick (
    .req_i   (rdy_vec),
    .grant_o (grant),
    .found_o (found)
  );

  // Woken values equal registered values for already-ready operands, so one mux serves both modes.
  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (grant[i]) sel_payload = woke[i].payload;
    end
  end

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign disp_fire  = io.disp_valid_i & disp_ready;
  assign iss_fire   = found & io.iss_ready_i;
  assign disp_slot  = iss_fire ? (count_q - CNT_W'(1)) : count_q;

  // Entries at or above the issued slot pull from the slot above; dispatch lands at the new tail.
  always_comb begin
    logic shift;
    shift   = 1'b0;
    valid_d = valid_q;
    entry_d = entry_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      shift = shift | (iss_fire & grant[i]);
      if (shift) begin
        valid_d[i] = valid_ext[i+1];
        entry_d[i] = woke[i+1];
      end else begin
        valid_d[i] = valid_q[i];
        entry_d[i] = woke[i];
      end
      if (disp_fire && (disp_slot == CNT_W'(i))) begin
        valid_d[i] = 1'b1;
        entry_d[i] = disp_woke;
      end
    end
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
  end

  always_ff @(posedge clk) begin
    if (rst || io.flush_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign io.disp_ready_o = disp_ready;
  assign io.iss_valid_o  = found;
  assign io.fuinput_o    = sel_payload;
  assign io.count_o      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed-vector bench for alu_issue_queue (DEPTH=8, WB_PORTS=2).
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  alu_issue_queue_if #(.DEPTH(8), .WB_PORTS(2)) io ();

  alu_issue_queue #(.DEPTH(8), .WB_PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic iq_uop_t mk(input logic [3:0] op,
                                 input prn_t prs1, input logic r1, input logic [31:0] v1,
                                 input prn_t prs2, input logic r2, input logic [31:0] v2);
    iq_uop_t u;
    u                = '0;
    u.payload.op     = op;
    u.payload.prd    = prn_t'(op);
    u.payload.rs1val = v1;
    u.payload.rs2val = v2;
    u.prs1           = prs1;
    u.prs2           = prs2;
    u.rs1_rdy        = r1;
    u.rs2_rdy        = r2;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io.flush_i      = 1'b0;
    io.disp_valid_i = 1'b0;
    io.disp_uop_i   = '0;
    io.wb_valid_i   = '0;
    io.wb_i         = '0;
    io.iss_ready_i  = 1'b0;
  endtask

  task automatic set_wb(input int p, input prn_t prd, input logic [31:0] val);
    io.wb_valid_i[p]  = 1'b1;
    io.wb_i[p].prd    = prd;
    io.wb_i[p].rdval  = val;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d exp 0", io.count_o); end
    vec++; if (io.iss_valid_o !== 1'b0) begin errs++; $display("FAIL reset_iss_valid: got %0b exp 0", io.iss_valid_o); end
    vec++; if (io.disp_ready_o !== 1'b1) begin errs++; $display("FAIL reset_disp_ready: got %0b exp 1", io.disp_ready_o); end
  endtask

  task automatic test_ready_dispatch();
    io.disp_valid_i = 1'b1;
    io.disp_uop_i   = mk(4'd1, '0, 1'b1, 32'd5, '0, 1'b1, 32'd7);
    io.iss_ready_i  = 1'b1;
    tick();
    io.disp_valid_i = 1'b0;
    vec++; if (io.iss_valid_o !== 1'b1) begin errs++; $display("FAIL rd_iss_valid: got %0b exp 1", io.iss_valid_o); end
    vec++; if (io.fuinput_o.rs1val !== 32'd5) begin errs++; $display("FAIL rd_rs1val: got %0h exp 5", io.fuinput_o.rs1val); end
    vec++; if (io.fuinput_o.rs2val !== 32'd7) begin errs++; $display("FAIL rd_rs2val: got %0h exp 7", io.fuinput_o.rs2val); end
    vec++; if (io.fuinput_o.op !== 4'd1) begin errs++; $display("FAIL rd_op: got %0d exp 1", io.fuinput_o.op); end
    vec++; if (io.count_o !== 4'd1) begin errs++; $display("FAIL rd_count1: got %0d exp 1", io.count_o); end
    tick();
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL rd_count0: got %0d exp 0", io.count_o); end
    vec++; if (io.iss_valid_o !== 1'b0) begin errs++; $display("FAIL rd_empty_iss: got %0b exp 0", io.iss_valid_o); end
  endtask

  task automatic test_wakeup_order();
    io.disp_valid_i = 1'b1;
    io.disp_uop_i   = mk(4'd2, prn_t'(12), 1'b0, 32'd0, '0, 1'b1, 32'd3);
    tick();
    io.disp_uop_i   = mk(4'd3, '0, 1'b1, 32'd1, '0, 1'b1, 32'd2);
    tick();
    io.disp_valid_i = 1'b0;
    vec++; if (io.count_o !== 4'd2) begin errs++; $display("FAIL wo_count2: got %0d exp 2", io.count_o); end
    vec++; if (io.fuinput_o.op !== 4'd3 || io.iss_valid_o !== 1'b1) begin errs++; $display("FAIL wo_b_first: got op %0d v %0b exp op 3 v 1", io.fuinput_o.op, io.iss_valid_o); end
    io.iss_ready_i = 1'b1;
    tick();
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd1 || io.iss_valid_o !== 1'b0) begin errs++; $display("FAIL wo_a_waiting: got cnt %0d v %0b exp cnt 1 v 0", io.count_o, io.iss_valid_o); end
    set_wb(0, prn_t'(12), 32'hDEAD);
    tick();
    idle();
    vec++; if (io.iss_valid_o !== 1'b1 || io.fuinput_o.op !== 4'd2) begin errs++; $display("FAIL wo_a_ready: got op %0d v %0b exp op 2 v 1", io.fuinput_o.op, io.iss_valid_o); end
    vec++; if (io.fuinput_o.rs1val !== 32'hDEAD) begin errs++; $display("FAIL wo_a_rs1: got %0h exp dead", io.fuinput_o.rs1val); end
    vec++; if (io.fuinput_o.rs2val !== 32'd3) begin errs++; $display("FAIL wo_a_rs2: got %0h exp 3", io.fuinput_o.rs2val); end
    io.iss_ready_i = 1'b1;
    tick();
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL wo_drain: got %0d exp 0", io.count_o); end
  endtask

  task automatic test_full();
    logic [3:0] exp_ops [7];
    exp_ops = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    io.disp_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io.disp_uop_i = mk(4'(i), '0, 1'b1, 32'(i), '0, 1'b1, 32'd0);
      tick();
    end
    vec++; if (io.count_o !== 4'd8) begin errs++; $display("FAIL full_count: got %0d exp 8", io.count_o); end
    vec++; if (io.disp_ready_o !== 1'b0) begin errs++; $display("FAIL full_ready: got %0b exp 0", io.disp_ready_o); end
    io.disp_uop_i  = mk(4'd9, '0, 1'b1, 32'd9, '0, 1'b1, 32'd0);
    io.iss_ready_i = 1'b1;
    tick();
    vec++; if (io.count_o !== 4'd7 || io.disp_ready_o !== 1'b1) begin errs++; $display("FAIL full_first_issue: got cnt %0d rdy %0b exp cnt 7 rdy 1", io.count_o, io.disp_ready_o); end
    vec++; if (io.fuinput_o.op !== 4'd1) begin errs++; $display("FAIL full_head1: got %0d exp 1", io.fuinput_o.op); end
    tick();
    io.disp_valid_i = 1'b0;
    vec++; if (io.count_o !== 4'd7) begin errs++; $display("FAIL full_disp_and_issue: got %0d exp 7", io.count_o); end
    for (int k = 0; k < 7; k++) begin
      vec++; if (io.iss_valid_o !== 1'b1 || io.fuinput_o.op !== exp_ops[k]) begin errs++; $display("FAIL full_drain%0d: got op %0d v %0b exp op %0d v 1", k, io.fuinput_o.op, io.iss_valid_o, exp_ops[k]); end
      tick();
    end
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL full_empty: got %0d exp 0", io.count_o); end
  endtask

  task automatic test_same_prd();
    io.disp_valid_i = 1'b1;
    io.disp_uop_i   = mk(4'd4, prn_t'(3), 1'b0, 32'd0, '0, 1'b1, 32'd0);
    tick();
    io.disp_valid_i = 1'b0;
    set_wb(0, prn_t'(3), 32'h11);
    set_wb(1, prn_t'(3), 32'h22);
    tick();
    idle();
    vec++; if (io.iss_valid_o !== 1'b1 || io.fuinput_o.rs1val !== 32'h11) begin errs++; $display("FAIL same_prd: got v %0b rs1 %0h exp v 1 rs1 11", io.iss_valid_o, io.fuinput_o.rs1val); end
    io.iss_ready_i = 1'b1;
    tick();
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL same_prd_drain: got %0d exp 0", io.count_o); end
  endtask

  task automatic test_back_to_back();
    io.disp_valid_i = 1'b1;
    io.disp_uop_i   = mk(4'd1, '0, 1'b1, 32'd0, '0, 1'b1, 32'd0);
    tick();
    io.disp_uop_i   = mk(4'd2, prn_t'(4), 1'b0, 32'd0, '0, 1'b1, 32'd0);
    tick();
    // Dispatch, issue and wakeup (including a shifting entry) in one cycle.
    io.disp_uop_i   = mk(4'd3, prn_t'(7), 1'b0, 32'd0, '0, 1'b1, 32'd1);
    io.iss_ready_i  = 1'b1;
    set_wb(0, prn_t'(4), 32'h44);
    set_wb(1, prn_t'(7), 32'h77);
    tick();
    idle();
    vec++; if (io.count_o !== 4'd2) begin errs++; $display("FAIL b2b_count: got %0d exp 2", io.count_o); end
    vec++; if (io.iss_valid_o !== 1'b1 || io.fuinput_o.op !== 4'd2 || io.fuinput_o.rs1val !== 32'h44) begin errs++; $display("FAIL b2b_shifted_wake: got v %0b op %0d rs1 %0h exp v 1 op 2 rs1 44", io.iss_valid_o, io.fuinput_o.op, io.fuinput_o.rs1val); end
    io.iss_ready_i = 1'b1;
    tick();
    vec++; if (io.fuinput_o.op !== 4'd3 || io.fuinput_o.rs1val !== 32'h77 || io.count_o !== 4'd1) begin errs++; $display("FAIL b2b_disp_wake: got op %0d rs1 %0h cnt %0d exp op 3 rs1 77 cnt 1", io.fuinput_o.op, io.fuinput_o.rs1val, io.count_o); end
    tick();
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL b2b_drain: got %0d exp 0", io.count_o); end
  endtask

  task automatic test_flush();
    io.disp_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      io.disp_uop_i = mk(4'(i + 1), '0, 1'b1, 32'd0, '0, 1'b1, 32'd0);
      tick();
    end
    vec++; if (io.count_o !== 4'd5) begin errs++; $display("FAIL flush_pre: got %0d exp 5", io.count_o); end
    io.disp_uop_i = mk(4'd15, '0, 1'b1, 32'd0, '0, 1'b1, 32'd0);
    io.flush_i    = 1'b1;
    tick();
    idle();
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL flush_count: got %0d exp 0", io.count_o); end
    vec++; if (io.iss_valid_o !== 1'b0) begin errs++; $display("FAIL flush_iss: got %0b exp 0", io.iss_valid_o); end
    vec++; if (io.disp_ready_o !== 1'b1) begin errs++; $display("FAIL flush_ready: got %0b exp 1", io.disp_ready_o); end
    tick();
    vec++; if (io.count_o !== 4'd0 || io.iss_valid_o !== 1'b0) begin errs++; $display("FAIL flush_dropped: got cnt %0d v %0b exp cnt 0 v 0", io.count_o, io.iss_valid_o); end
  endtask

  task automatic test_wakeup_latency();
    io.disp_valid_i = 1'b1;
    io.disp_uop_i   = mk(4'd5, prn_t'(9), 1'b0, 32'd0, '0, 1'b1, 32'd0);
    tick();
    io.disp_valid_i = 1'b0;
    set_wb(0, prn_t'(9), 32'h99);
`ifdef IQ_WAKEUP_BYPASS_EN
    io.iss_ready_i = 1'b1;
    #1;
    vec++; if (io.iss_valid_o !== 1'b1 || io.fuinput_o.rs1val !== 32'h99) begin errs++; $display("FAIL byp_same_cycle: got v %0b rs1 %0h exp v 1 rs1 99", io.iss_valid_o, io.fuinput_o.rs1val); end
    tick();
    idle();
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL byp_drain: got %0d exp 0", io.count_o); end
`else
    #1;
    vec++; if (io.iss_valid_o !== 1'b0) begin errs++; $display("FAIL lat_no_bypass: got %0b exp 0", io.iss_valid_o); end
    tick();
    idle();
    vec++; if (io.iss_valid_o !== 1'b1 || io.fuinput_o.rs1val !== 32'h99) begin errs++; $display("FAIL lat_next_cycle: got v %0b rs1 %0h exp v 1 rs1 99", io.iss_valid_o, io.fuinput_o.rs1val); end
    io.iss_ready_i = 1'b1;
    tick();
    io.iss_ready_i = 1'b0;
    vec++; if (io.count_o !== 4'd0) begin errs++; $display("FAIL lat_drain: got %0d exp 0", io.count_o); end
`endif
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst  = 1'b1;
    idle();
    test_reset();
    test_ready_dispatch();
    test_wakeup_order();
    test_full();
    test_same_prd();
    test_back_to_back();
    test_flush();
    test_wakeup_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Data-capture issue queue that sits directly upstream of the ALU functional unit and produces its fu_input_t each cycle.
- Buffers up to DEPTH dispatched ALU micro-ops and captures source operand values from writeback broadcasts.
- Issues the oldest fully-ready op to the ALU through a valid/ready handshake.
- Flush empties the queue; there is no partial squash.

Parameters:
- DEPTH, 8, number of queue entries; must be at least 2.
- WB_PORTS, 2, number of writeback broadcast ports used for wakeup.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high. One clock domain.
- flush_i  in  1  kill all entries.
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  queue can accept an op.
- disp_uop_i  in  iq_uop_t  fields: fu_input_t payload, prs1, prs2, rs1_rdy, rs2_rdy.
- wb_valid_i  in  WB_PORTS  per-port broadcast valid.
- wb_i  in  WB_PORTS x fu_output_t  broadcast payload; uses the prd and rdval fields.
- iss_valid_o  out  1  fuinput_o holds a ready op.
- iss_ready_i  in  1  ALU accepts the op.
- fuinput_o  out  fu_input_t  op presented to the ALU.
- count_o  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset and flush: rst (sync, high) or flush_i clears every entry valid bit and sets count to 0. After the edge, iss_valid_o=0, disp_ready_o=1, count_o=0. Data fields are don't-care. A dispatch or issue in the same cycle as reset or flush is dropped.
- Storage: collapsing queue; entry 0 is the oldest. Each entry holds valid, uop, rs1_rdy, rs2_rdy and captured rs1val/rs2val.
- Dispatch: accepted on disp_valid_i && disp_ready_o. disp_ready_o = (count < DEPTH) and is based on registered count only; an issue in the same cycle does not free space. The op is written to slot count, or to slot count-1 if an issue compacts the queue in that cycle.
- Dispatch-time wakeup: if a wb port matches prs1/prs2 of the dispatching op in the same cycle, the value is captured and the ready bit set.
- Wakeup: every cycle, each valid entry with an operand not ready compares prs against all valid wb ports. On a match it latches rdval and sets rdy at the edge.
  - If two ports carry the same prd, the lowest port index wins.
  - prs==0 always arrives with rdy=1 and value 0; the dispatcher guarantees this.
- Select: the lowest-index entry with both rdy bits set, evaluated on registered state. iss_valid_o is high if such an entry exists. fuinput_o is that entry's payload with rs1val/rs2val substituted.
- Issue: on iss_valid_o && iss_ready_i the entry is removed and entries above it shift down by one, keeping age order. One issue per cycle.
- Stall: while iss_ready_i=0, the selection may change only because an older entry became ready. The ALU tolerates this; there is no lock.
- Latency: minimum dispatch to iss_valid_o is 1 cycle (op ready at dispatch). For an op woken by a wb broadcast, issue is 1 cycle after the broadcast.
- count_o: next = count + accepted dispatch - accepted issue.
- Boundaries:
  - Empty queue: iss_valid_o=0.
  - Full queue: disp_ready_o=0 even if issuing.
  - Dispatch, wakeup and issue in the same cycle are all honoured.
  - A wakeup arriving while an entry shifts goes to the entry's new slot.

Optional Feature:
- Macro IQ_WAKEUP_BYPASS_EN.
- Defined: select also considers operands matched by this cycle's wb ports (combinational bypass). fuinput_o muxes in wb rdval, so an op can issue in the same cycle as its producer's broadcast. This saves 1 cycle of latency at a timing cost.
- Undefined: select uses registered rdy bits only, as described in Behaviour.

Decomposition:
- Package: iq_uop_t, prn_t, and the IQ_CNT_W helper constant. fu_input_t and fu_output_t already live there.
- Sub-module iq_oldest_ready_pick: DEPTH-wide lowest-index priority picker that outputs a one-hot grant and a found flag. It is instantiated once for select.

Test Plan:
- Reset, then dispatch an op with both rdy=1, rs1val=5, rs2val=7, iss_ready_i=1 -> iss_valid_o high next cycle with matching fuinput_o; count returns 0 one cycle later.
- Dispatch op A (prs1=12, not ready) then ready op B -> B issues first. wb prd=12, rdval=0xDEAD -> A issues the next cycle with rs1val=0xDEAD.
- Fill 8 entries with iss_ready_i=0 -> disp_ready_o=0 and count_o=8. Raise iss_ready_i with disp_valid_i held -> one issue per cycle; disp_ready_o returns after the first issue.
- Both wb ports broadcast prd=3, values 0x11 and 0x22, to a waiting entry -> the captured value is 0x11.
- flush_i while holding 5 entries and a simultaneous dispatch -> count_o=0, iss_valid_o=0 next cycle, and the dispatched op is not retained.
- With IQ_WAKEUP_BYPASS_EN defined: wb prd=9 in cycle N with an entry waiting on 9 -> iss_valid_o in cycle N, with rs1val equal to the broadcast value.
